// File: rtl/apb_sensor_poll_master.sv
// Round-robin APB read master: polls each sensor slave's data register and forwards each
// result (or error/timeout) as a one-cycle tagged sample.
module apb_sensor_poll_master #(
  parameter int unsigned NUM_SENSORS   = 4,
  parameter int unsigned IDX_W         = $clog2(NUM_SENSORS),
  parameter logic [31:0] DATA_REG_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned POLL_INTERVAL = 64
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   poll_en,
  output logic [31:0]            PADDR,
  output logic [NUM_SENSORS-1:0] PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  input  logic [31:0]            PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  output logic                   sample_valid,
  output logic [31:0]            sample_data,
  output logic [IDX_W-1:0]       sample_idx,
  output logic [1:0]             sample_status,
  output logic                   busy
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GapW  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(POLL_INTERVAL - 1);
  localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(NUM_SENSORS - 1);

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusSlvErr  = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;

  // StTurn is the single idle bus cycle between transfers of the same round.
  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StTurn, StGap} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              done;
  logic              timed_out;

  logic              sample_valid_q;
  logic [31:0]       sample_data_q;
  logic [IDX_W-1:0]  sample_idx_q;
  logic [1:0]        sample_status_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    done      = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (poll_en) begin
          state_d = StSetup;
          idx_d   = '0;
        end
      end
      StSetup: begin
        state_d = StAccess;
        wait_d  = '0;
      end
      StAccess: begin
        if (PREADY) begin
          done = 1'b1;
        end else if (wait_q == WaitLast) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
        // poll_en only matters once the in-flight transfer has finished.
        if (done) begin
          if (!poll_en) begin
            state_d = StIdle;
            idx_d   = '0;
          end else if (idx_q != IdxLast) begin
            state_d = StTurn;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            idx_d   = '0;
            gap_d   = '0;
            state_d = (POLL_INTERVAL == 0) ? StSetup : StGap;
          end
        end
      end
      StTurn: begin
        state_d = StSetup;
      end
      StGap: begin
        if (!poll_en) begin
          state_d = StIdle;
        end else if (gap_q == GapLast) begin
          state_d = StSetup;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sample_valid_q  <= 1'b0;
      sample_data_q   <= '0;
      sample_idx_q    <= '0;
      sample_status_q <= StatusOk;
    end else begin
      sample_valid_q <= done;
      if (done) begin
        sample_idx_q <= idx_q;
        if (timed_out) begin
          sample_data_q   <= '0;
          sample_status_q <= StatusTimeout;
        end else if (PSLVERR) begin
          sample_data_q   <= '0;
          sample_status_q <= StatusSlvErr;
        end else begin
          sample_data_q   <= PRDATA;
          sample_status_q <= StatusOk;
        end
      end
    end
  end

  // Bus outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    PSEL    = '0;
    PADDR   = '0;
    PENABLE = 1'b0;
    busy    = 1'b0;
    if (state_q == StSetup || state_q == StAccess) begin
      PSEL[idx_q] = 1'b1;
      PADDR       = DATA_REG_ADDR;
    end
    if (state_q == StAccess) begin
      PENABLE = 1'b1;
    end
    if (state_q == StSetup || state_q == StAccess || state_q == StTurn) begin
      busy = 1'b1;
    end
  end

  assign PWRITE        = 1'b0;
  assign sample_valid  = sample_valid_q;
  assign sample_data   = sample_data_q;
  assign sample_idx    = sample_idx_q;
  assign sample_status = sample_status_q;

  psel_onehot: assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(PSEL));
  penable_has_psel: assert property (@(posedge PCLK) disable iff (PRESET) PENABLE |-> |PSEL);

endmodule
